// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared opcodes, ALU sub-ops and reservation-station entry type
package alu_rs_pkg;
  localparam int ROB_W = 5;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_GE, ALU_GEU
  } alu_op_e;
  typedef struct packed {
    logic busy;
    logic [ROB_W-1:0] rob_id;
    logic [6:0] opc;
    logic [3:0] op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic p1;
    logic p2;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
  } rs_entry_t;
endpackage

// File: rtl/alu_rs_pick.sv
// alu_rs_pick: lowest-index priority encoder
module alu_rs_pick #(
  parameter int N = 8,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);
  always_comb begin
    found = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
  end
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with dual-CDB wakeup and single-issue select
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             _clear,
  input  logic             _dis_valid,
  input  logic [ROB_W-1:0] _dis_rob_id,
  input  logic [6:0]       _dis_type,
  input  logic [3:0]       _dis_op,
  input  logic [31:0]      _dis_v1,
  input  logic [31:0]      _dis_v2,
  input  logic             _dis_q1_busy,
  input  logic             _dis_q2_busy,
  input  logic [ROB_W-1:0] _dis_q1,
  input  logic [ROB_W-1:0] _dis_q2,
  output logic             _rs_full,
  input  logic             _alu_cdb_ready,
  input  logic [ROB_W-1:0] _alu_cdb_rob_id,
  input  logic [31:0]      _alu_cdb_value,
  input  logic             _lsb_cdb_ready,
  input  logic [ROB_W-1:0] _lsb_cdb_rob_id,
  input  logic [31:0]      _lsb_cdb_value,
  output logic             _alu_ready,
  output logic [ROB_W-1:0] _alu_rob_id,
  output logic [6:0]       _alu_type,
  output logic [3:0]       _alu_op,
  output logic [31:0]      _alu_v1,
  output logic [31:0]      _alu_v2
);
  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;
  rs_entry_t rs [RS_SIZE];
  rs_entry_t new_e;
  logic [CW-1:0] count;
  logic [RS_SIZE-1:0] free_vec, rdy_vec;
  logic free_found, rdy_found, accept;
  logic [IW-1:0] free_idx, rdy_idx;
  function automatic logic a_hit(input logic [ROB_W-1:0] q);
    return _alu_cdb_ready && _alu_cdb_rob_id == q;
  endfunction
  function automatic logic l_hit(input logic [ROB_W-1:0] q);
    return _lsb_cdb_ready && _lsb_cdb_rob_id == q;
  endfunction
  function automatic logic [31:0] fwd(input logic [ROB_W-1:0] q, input logic [31:0] v);
    return a_hit(q) ? _alu_cdb_value : l_hit(q) ? _lsb_cdb_value : v;
  endfunction
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i] = !rs[i].busy;
      rdy_vec[i] = rs[i].busy && !rs[i].p1 && !rs[i].p2;
    end
  end
  alu_rs_pick #(.N(RS_SIZE)) u_free (.req(free_vec), .found(free_found), .idx(free_idx));
  alu_rs_pick #(.N(RS_SIZE)) u_rdy (.req(rdy_vec), .found(rdy_found), .idx(rdy_idx));
  assign _rs_full = count == CW'(RS_SIZE);
  assign accept = _dis_valid && !_rs_full && free_found;
  always_comb begin
    new_e = '0;
    new_e.busy = 1'b1;
    new_e.rob_id = _dis_rob_id;
    new_e.opc = _dis_type;
    new_e.op = _dis_op;
    new_e.q1 = _dis_q1;
    new_e.q2 = _dis_q2;
    new_e.p1 = _dis_q1_busy && !a_hit(_dis_q1) && !l_hit(_dis_q1);
    new_e.p2 = _dis_q2_busy && !a_hit(_dis_q2) && !l_hit(_dis_q2);
    new_e.v1 = _dis_q1_busy ? fwd(_dis_q1, _dis_v1) : _dis_v1;
    new_e.v2 = _dis_q2_busy ? fwd(_dis_q2, _dis_v2) : _dis_v2;
  end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) rs[i] <= '0;
      count <= '0;
      _alu_ready <= 1'b0;
      _alu_rob_id <= '0;
      _alu_type <= '0;
      _alu_op <= '0;
      _alu_v1 <= '0;
      _alu_v2 <= '0;
    end else if (rdy_in) begin
      if (_clear) begin
        for (int i = 0; i < RS_SIZE; i++) rs[i].busy <= 1'b0;
        count <= '0;
        _alu_ready <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (rs[i].busy && rs[i].p1 && (a_hit(rs[i].q1) || l_hit(rs[i].q1))) begin
            rs[i].v1 <= fwd(rs[i].q1, rs[i].v1);
            rs[i].p1 <= 1'b0;
          end
          if (rs[i].busy && rs[i].p2 && (a_hit(rs[i].q2) || l_hit(rs[i].q2))) begin
            rs[i].v2 <= fwd(rs[i].q2, rs[i].v2);
            rs[i].p2 <= 1'b0;
          end
        end
        _alu_ready <= rdy_found;
        if (rdy_found) begin
          rs[rdy_idx].busy <= 1'b0;
          _alu_rob_id <= rs[rdy_idx].rob_id;
          _alu_type <= rs[rdy_idx].opc;
          _alu_op <= rs[rdy_idx].op;
          _alu_v1 <= rs[rdy_idx].v1;
          _alu_v2 <= rs[rdy_idx].v2;
        end
        if (accept) rs[free_idx] <= new_e;
        count <= count + CW'(accept) - CW'(rdy_found);
      end
    end
  end
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed vectors for the ALU reservation station
module tb_alu_rs;
  import alu_rs_pkg::*;
  logic clk = 0, rst_n = 0, rdy = 1, clear = 0;
  logic dis_valid = 0, q1_busy = 0, q2_busy = 0;
  logic [4:0] dis_rob = 0, q1 = 0, q2 = 0;
  logic [6:0] dis_type = 0;
  logic [3:0] dis_op = 0;
  logic [31:0] v1 = 0, v2 = 0;
  logic acdb = 0, lcdb = 0;
  logic [4:0] acdb_rob = 0, lcdb_rob = 0;
  logic [31:0] acdb_val = 0, lcdb_val = 0;
  logic full, alu_ready;
  logic [4:0] alu_rob;
  logic [6:0] alu_type;
  logic [3:0] alu_op;
  logic [31:0] alu_v1, alu_v2;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  alu_rs dut (
    .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy), ._clear(clear),
    ._dis_valid(dis_valid), ._dis_rob_id(dis_rob), ._dis_type(dis_type), ._dis_op(dis_op),
    ._dis_v1(v1), ._dis_v2(v2), ._dis_q1_busy(q1_busy), ._dis_q2_busy(q2_busy),
    ._dis_q1(q1), ._dis_q2(q2), ._rs_full(full),
    ._alu_cdb_ready(acdb), ._alu_cdb_rob_id(acdb_rob), ._alu_cdb_value(acdb_val),
    ._lsb_cdb_ready(lcdb), ._lsb_cdb_rob_id(lcdb_rob), ._lsb_cdb_value(lcdb_val),
    ._alu_ready(alu_ready), ._alu_rob_id(alu_rob), ._alu_type(alu_type), ._alu_op(alu_op),
    ._alu_v1(alu_v1), ._alu_v2(alu_v2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic dis(input logic [4:0] rob, input logic b1, input logic [4:0] t1, input logic [31:0] a,
                     input logic b2, input logic [4:0] t2, input logic [31:0] b);
    dis_valid = 1; dis_rob = rob; dis_type = OP_R; dis_op = ALU_ADD;
    q1_busy = b1; q1 = t1; v1 = a; q2_busy = b2; q2 = t2; v2 = b;
    @(negedge clk);
    dis_valid = 0;
  endtask
  task automatic bcast_alu(input logic [4:0] tag, input logic [31:0] val);
    acdb = 1; acdb_rob = tag; acdb_val = val;
    @(negedge clk);
    acdb = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", alu_ready, 0);
    chk("rst_full", full, 0);
    chk("rst_rob", alu_rob, 0);
    chk("rst_v1", alu_v1, 0);
    rst_n = 1;
    @(negedge clk);
    // frozen cycle: dispatch must not land
    rdy = 0;
    dis(5'd8, 0, 0, 32'h1, 0, 0, 32'h2);
    rdy = 1;
    @(negedge clk);
    chk("frozen_no_issue", alu_ready, 0);
    dis(5'd3, 0, 0, 32'd5, 0, 0, 32'd7);
    chk("ready_not_early", alu_ready, 0);
    @(negedge clk);
    chk("ready_pulse", alu_ready, 1);
    chk("ready_rob", alu_rob, 3);
    chk("ready_type", alu_type, OP_R);
    chk("ready_op", alu_op, ALU_ADD);
    chk("ready_v1", alu_v1, 5);
    chk("ready_v2", alu_v2, 7);
    @(negedge clk);
    chk("ready_one_cycle", alu_ready, 0);
    dis(5'd4, 1, 5'd2, 32'h0, 0, 0, 32'd3);
    chk("wake_wait", alu_ready, 0);
    bcast_alu(5'd2, 32'h10);
    chk("wake_same_cycle", alu_ready, 0);
    @(negedge clk);
    chk("wake_issue", alu_ready, 1);
    chk("wake_rob", alu_rob, 4);
    chk("wake_v1", alu_v1, 32'h10);
    chk("wake_v2", alu_v2, 3);
    lcdb = 1; lcdb_rob = 5'd6; lcdb_val = 32'hAB;
    dis(5'd5, 0, 0, 32'd1, 1, 5'd6, 32'h0);
    lcdb = 0;
    @(negedge clk);
    chk("fwd_issue", alu_ready, 1);
    chk("fwd_rob", alu_rob, 5);
    chk("fwd_v2", alu_v2, 32'hAB);
    for (int i = 0; i < 8; i++) dis(5'(10 + i), 1, 5'd9, 32'h0, 0, 0, 32'(i));
    chk("full_set", full, 1);
    dis(5'd20, 0, 0, 32'h1, 0, 0, 32'h1);
    chk("full_drop_issue", alu_ready, 0);
    chk("full_hold", full, 1);
    bcast_alu(5'd9, 32'h99);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_ready", i), alu_ready, 1);
      chk($sformatf("drain%0d_rob", i), alu_rob, 32'(10 + i));
      chk($sformatf("drain%0d_v2", i), alu_v2, 32'(i));
    end
    @(negedge clk);
    chk("drain_done", alu_ready, 0);
    chk("drain_full", full, 0);
    for (int i = 0; i < 3; i++) dis(5'(1 + i), 1, 5'd9, 32'h0, 0, 0, 32'h0);
    clear = 1;
    dis(5'd7, 0, 0, 32'h1, 0, 0, 32'h1);
    clear = 0;
    chk("clr_full", full, 0);
    bcast_alu(5'd9, 32'h55);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("clr_quiet%0d", i), alu_ready, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 7; i++) dis(5'(1 + i), 1, 5'd9, 32'h0, 0, 0, 32'h0);
    chk("clr_count7", full, 0);
    dis(5'd8, 1, 5'd9, 32'h0, 0, 0, 32'h0);
    chk("clr_count8", full, 1);
    bcast_alu(5'd9, 32'h77);
    @(negedge clk);
    chk("arst_issuing", alu_ready, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_ready", alu_ready, 0);
    chk("arst_full", full, 0);
    chk("arst_rob", alu_rob, 0);
    #1 rst_n = 1;
    @(negedge clk);
    bcast_alu(5'd9, 32'h77);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("arst_quiet%0d", i), alu_ready, 0);
      @(negedge clk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
